cache_fill_responder: RTL and testbench

Backing-memory responder on the refill side of the L1 `Cache`. It accepts single-word read (line fill) and write requests from the cache controller and holds a 4096 x 64-bit word store. Read data returns as a byte-serial burst with a valid/ready handshake, so the cache can assemble a 64-bit word one beat at a time.

---
 rtl/cache_fill_responder.sv | 143 ++++++++++++++
 tb/tb_cache_fill_responder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_responder.sv
// Backing word store for L1 line refills: single-word read/write requests, reads returned as a byte-serial
// valid/ready burst. Define CACHE_FILL_CRIT_BEAT_EN to start each burst at the requested (critical) beat.
module cache_fill_responder #(
    parameter int ADDR_WID = 12,
    parameter int WORD_WID = 64,
    parameter int BEAT_WID = 8,
    parameter int LATENCY  = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic                                  req_we_i,
    input  logic [ADDR_WID-1:0]                   req_addr_i,
    input  logic [$clog2(WORD_WID/BEAT_WID)-1:0]  req_byte_i,
    input  logic [WORD_WID-1:0]                   req_wdata_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [BEAT_WID-1:0]                   rsp_data_o,
    output logic [$clog2(WORD_WID/BEAT_WID)-1:0]  rsp_beat_o,
    output logic                                  rsp_last_o
);

    localparam int BEATS  = WORD_WID / BEAT_WID;
    localparam int IDX_W  = $clog2(BEATS);
    localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BEATS - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WACK
    } state_e;

    state_e                         state_q;
    logic [WORD_WID-1:0]            mem [2**ADDR_WID];
    logic [WORD_WID-1:0]            line_q;
    logic [BEATS-1:0][BEAT_WID-1:0] line_beats;
    logic [IDX_W-1:0]               beat_q;
    logic [IDX_W-1:0]               issued_q;
    logic [WAIT_W-1:0]              wait_q;
    logic                           req_fire;
    logic [IDX_W-1:0]               start_beat;

    assign req_fire    = req_valid_i && (state_q == IDLE);
    assign req_ready_o = (state_q == IDLE);
    assign line_beats  = line_q;

`ifdef CACHE_FILL_CRIT_BEAT_EN
    assign start_beat = req_byte_i;
`else
    logic unused_req_byte;
    assign unused_req_byte = ^req_byte_i;
    assign start_beat      = '0;
`endif

    // NOTE: the store and the line register carry no reset, so the array maps onto block RAM
    // and its contents survive rst_ni; only the control path below is reset.
    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            if (req_we_i) begin
                mem[req_addr_i] <= req_wdata_i;
            end else begin
                line_q <= mem[req_addr_i];
            end
        end
    end

    // NOTE: every register here is assigned with <= so all updates see the pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            issued_q <= '0;
            wait_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (req_we_i) begin
                            state_q <= WACK;
                        end else begin
                            beat_q   <= start_beat;
                            issued_q <= '0;
                            if (LATENCY > 0) begin
                                state_q <= WAIT;
                                wait_q  <= WAIT_INIT;
                            end else begin
                                state_q <= BURST;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= BURST;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                BURST: begin
                    if (rsp_ready_i) begin
                        beat_q   <= (beat_q == LAST_IDX) ? '0 : beat_q + 1'b1;
                        issued_q <= issued_q + 1'b1;
                        if (issued_q == LAST_IDX) begin
                            state_q <= IDLE;
                        end
                    end
                end
                WACK: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_last_o  = 1'b0;
        rsp_data_o  = '0;
        rsp_beat_o  = '0;
        case (state_q)
            BURST: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = line_beats[beat_q];
                rsp_beat_o  = beat_q;
                rsp_last_o  = (issued_q == LAST_IDX);
            end
            WACK: begin
                rsp_valid_o = 1'b1;
                rsp_last_o  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_responder.sv
// Self-checking bench for cache_fill_responder: a transaction-level model predicts every response beat
// and its earliest visible cycle; directed sequences pin latency, ordering, backpressure and reset.
module tb_cache_fill_responder;

    localparam int LAT   = 2;
    localparam int BEATS = 8;
    localparam logic [63:0] LIT_WORD = 64'h0706050403020100;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, sel = 1'b0;
    logic [11:0] req_addr = '0;
    logic [2:0]  req_byte = '0;
    logic [63:0] req_wdata = '0;

    logic       req_valid_a, req_ready_a, rsp_valid_a, rsp_last_a;
    logic [7:0] rsp_data_a;
    logic [2:0] rsp_beat_a;
    logic       req_valid_b, req_ready_b, rsp_valid_b, rsp_last_b;
    logic [7:0] rsp_data_b;
    logic [2:0] rsp_beat_b;
    logic       m_req_ready, m_rsp_valid, m_rsp_last;
    logic [7:0] m_rsp_data;
    logic [2:0] m_rsp_beat;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk_i = ~clk_i;

    assign req_valid_a = req_valid && !sel;
    assign req_valid_b = req_valid && sel;
    assign m_req_ready = sel ? req_ready_b : req_ready_a;
    assign m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign m_rsp_last  = sel ? rsp_last_b  : rsp_last_a;
    assign m_rsp_data  = sel ? rsp_data_b  : rsp_data_a;
    assign m_rsp_beat  = sel ? rsp_beat_b  : rsp_beat_a;

    cache_fill_responder #(.LATENCY(LAT)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_byte_i(req_byte), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_a),
        .rsp_beat_o(rsp_beat_a), .rsp_last_o(rsp_last_a)
    );

    cache_fill_responder #(.LATENCY(0)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_byte_i(req_byte), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_b),
        .rsp_beat_o(rsp_beat_b), .rsp_last_o(rsp_last_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int start_of(input int b);
`ifdef CACHE_FILL_CRIT_BEAT_EN
        return b;
`else
        return 0;
`endif
    endfunction

    // Reference model for the LATENCY=LAT instance: pending beats with the edge after which they show.
    typedef struct {
        logic [7:0] data;
        logic [2:0] beat;
        logic       last;
        int         start;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] model_mem [int];

    always @(posedge clk_i) begin : p_model
        bit          rdy_e, vld_e;
        int          b0;
        logic [63:0] w;
        beat_t       e;
        rdy_e = (exp_q.size() == 0);
        vld_e = !rdy_e && (cyc >= exp_q[0].start);
        cyc++;
        if (!rst_ni) begin
            exp_q.delete();
        end else begin
            if (vld_e && rsp_ready) void'(exp_q.pop_front());
            if (rdy_e && req_valid_a) begin
                if (req_we) begin
                    model_mem[int'(req_addr)] = req_wdata;
                    e.data = '0; e.beat = '0; e.last = 1'b1; e.start = cyc;
                    exp_q.push_back(e);
                end else begin
                    w  = model_mem[int'(req_addr)];
                    b0 = start_of(int'(req_byte));
                    for (int k = 0; k < BEATS; k++) begin
                        e.beat  = 3'((b0 + k) % BEATS);
                        e.data  = w[int'(e.beat) * 8 +: 8];
                        e.last  = (k == BEATS - 1);
                        e.start = cyc + LAT;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    always @(negedge clk_i) begin : p_compare
        bit rdy_e, vld_e;
        if (!rst_ni) begin
            check("reset_req_ready", req_ready_a, 1);
            check("reset_rsp_valid", rsp_valid_a, 0);
            check("reset_rsp_data", rsp_data_a, 0);
            check("reset_rsp_beat", rsp_beat_a, 0);
            check("reset_rsp_last", rsp_last_a, 0);
        end else begin
            rdy_e = (exp_q.size() == 0);
            vld_e = !rdy_e && (cyc >= exp_q[0].start);
            check("model_req_ready", req_ready_a, rdy_e);
            check("model_rsp_valid", rsp_valid_a, vld_e);
            if (vld_e) begin
                check("model_rsp_data", rsp_data_a, exp_q[0].data);
                check("model_rsp_beat", rsp_beat_a, exp_q[0].beat);
                check("model_rsp_last", rsp_last_a, exp_q[0].last);
            end
        end
    end

    logic [7:0] got_data [BEATS];
    logic [2:0] got_beat [BEATS];
    logic       got_last [BEATS];

    // Entered and left at negedge+2; returns the edge at which the request was taken.
    task automatic send_req(input bit we, input logic [11:0] a, input logic [2:0] b,
                            input logic [63:0] d, output int acc_edge);
        bit seen;
        bit done = 0;
        acc_edge = -1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_byte = b; req_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            seen = m_req_ready;
            @(posedge clk_i); #1;
            if (seen) begin
                done = 1;
                acc_edge = cyc;
            end
        end
        check("req_accept_timeout", done, 1);
        @(negedge clk_i); #2;
        req_valid = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic collect(input int mode, output int first_edge, output int last_edge, output int nbeats);
        bit         v, r, l, pv, pr, pl, done;
        logic [7:0] d, pd;
        logic [2:0] bt, pb;
        done = 0; pv = 0; pr = 0; pl = 0; pd = '0; pb = '0;
        first_edge = -1; last_edge = -1; nbeats = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (i % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            rsp_ready = r;
            v = m_rsp_valid; l = m_rsp_last; d = m_rsp_data; bt = m_rsp_beat;
            if (v && first_edge < 0) first_edge = cyc + 1;
            if (v) check("req_ready_low_while_busy", m_req_ready, 0);
            if (pv && !pr) begin
                check("hold_valid", v, 1);
                check("hold_data", d, pd);
                check("hold_beat", bt, pb);
                check("hold_last", l, pl);
            end
            pv = v; pr = r; pd = d; pb = bt; pl = l;
            @(posedge clk_i); #1;
            if (v && r) begin
                if (nbeats < BEATS) begin
                    got_data[nbeats] = d; got_beat[nbeats] = bt; got_last[nbeats] = l;
                end
                nbeats++;
                if (l) begin
                    done = 1;
                    last_edge = cyc;
                end
            end
            if (!done) begin
                @(negedge clk_i); #2;
            end
        end
        check("rsp_timeout", done, 1);
        @(negedge clk_i); #2;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [63:0] d, input int mode);
        int acc, fe, le, n;
        send_req(1'b1, a, 3'd0, d, acc);
        collect(mode, fe, le, n);
        check("wack_count", n, 1);
        check("wack_data", got_data[0], 0);
        check("wack_beat", got_beat[0], 0);
        check("wack_last", got_last[0], 1);
        check("wack_latency", fe - acc, 1);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [2:0] b, input int mode,
                           input logic [63:0] word, output int acc, output int le);
        int fe, n, s, lat, idx;
        lat = sel ? 0 : LAT;
        send_req(1'b0, a, b, '0, acc);
        collect(mode, fe, le, n);
        check("read_beat_count", n, BEATS);
        check("read_first_latency", fe - acc, lat + 1);
        if (mode == 0) check("read_last_edge", le - acc, lat + BEATS);
        s = start_of(int'(b));
        for (int k = 0; k < BEATS; k++) begin
            idx = (s + k) % BEATS;
            check("read_beat_index", got_beat[k], idx);
            check("read_beat_data", got_data[k], word[idx * 8 +: 8]);
            check("read_beat_last", got_last[k], k == BEATS - 1);
        end
    endtask

    initial begin : p_timeout
        #400000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin : p_stim
        int          acc, le, acc2, le2, hs;
        bit          v;
        logic [11:0] pool [16];
        logic [11:0] a;
        logic [63:0] wa, wb;

        repeat (3) @(negedge clk_i);
        #2;
        check("lit_reset_ready", req_ready_a, 1);
        check("lit_reset_valid", rsp_valid_a, 0);
        rst_ni = 1'b1;
        @(negedge clk_i); #2;

        // Directed: write then reads, plain and with backpressure.
        do_write(12'h010, LIT_WORD, 0);
        do_read(12'h010, 3'd5, 0, LIT_WORD, acc, le);
`ifdef CACHE_FILL_CRIT_BEAT_EN
        check("lit_crit_first", got_data[0], 8'h05);
        check("lit_crit_last", got_data[7], 8'h04);
`else
        check("lit_plain_first", got_data[0], 8'h00);
        check("lit_plain_last", got_data[7], 8'h07);
`endif
        check("lit_first_beat_edge", acc + 3, le - 7);
        do_read(12'h010, 3'd0, 1, LIT_WORD, acc, le);

        // Reset while beat 3 is presented.
        send_req(1'b0, 12'h010, 3'd0, '0, acc);
        hs = 0;
        for (int i = 0; i < 40 && hs < 3; i++) begin
            rsp_ready = 1'b1;
            v = rsp_valid_a;
            @(posedge clk_i); #1;
            if (v) hs++;
            if (hs < 3) begin
                @(negedge clk_i); #2;
            end
        end
        @(negedge clk_i); #2;
        rsp_ready = 1'b0;
        check("lit_beat3_valid", rsp_valid_a, 1);
        check("lit_beat3_index", rsp_beat_a, 3);
        rst_ni = 1'b0;
        #1;
        check("lit_reset_drops_valid", rsp_valid_a, 0);
        check("lit_reset_ready_high", req_ready_a, 1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #2;
        rst_ni = 1'b1;
        @(negedge clk_i); #2;
        do_read(12'h010, 3'd0, 0, LIT_WORD, acc, le);
        check("lit_retained_word_b2", got_data[2], 8'h02);

        // Zero-latency instance: boundary addresses, back-to-back reads.
        sel = 1'b1;
        wa = 64'hF0E1D2C3B4A59687;
        wb = 64'h1122334455667788;
        do_write(12'hFFF, wa, 0);
        do_write(12'h000, wb, 0);
        do_read(12'hFFF, 3'd0, 0, wa, acc, le);
        do_read(12'h000, 3'd0, 0, wb, acc2, le2);
        check("lat0_back_to_back_accept", acc2, le + 1);
        check("lat0_last_edge", le2 - acc2, BEATS);
        sel = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 16; i++) pool[i] = 12'($urandom);
        pool[0] = 12'hFFF;
        pool[1] = 12'h000;
        for (int t = 0; t < 60; t++) begin
            a = pool[$urandom_range(0, 15)];
            if (!model_mem.exists(int'(a)) || ($urandom_range(0, 2) == 0)) begin
                do_write(a, {$urandom, $urandom}, 2);
            end else begin
                do_read(a, 3'($urandom), 2, model_mem[int'(a)], acc, le);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            #2;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
